// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: latches a packed hex value,
// scans one digit per slot with a one-cycle blanking guard, optional leading-zero blanking.
module seg_scan_driver #(
  parameter int NUM_DIGITS       = 4,
  parameter int SCAN_DIV         = 50000,
  parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW}};

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_pend_val;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [4*NUM_DIGITS-1:0] r_shad_val;
  logic [NUM_DIGITS-1:0]   r_shad_dp;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_done;

  logic                    w_tick;
  logic                    w_wrap;
  logic [3:0]              w_digit;
  logic                    w_dp_bit;
  logic                    w_blank;
  logic                    w_all_zero;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic [6:0]              w_seg_nxt;
  logic                    w_dp_nxt;
  logic [NUM_DIGITS-1:0]   w_an_nxt;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    case (d)
      4'h0: f_decode = 7'h01;
      4'h1: f_decode = 7'h4F;
      4'h2: f_decode = 7'h12;
      4'h3: f_decode = 7'h06;
      4'h4: f_decode = 7'h4C;
      4'h5: f_decode = 7'h24;
      4'h6: f_decode = 7'h20;
      4'h7: f_decode = 7'h0F;
      4'h8: f_decode = 7'h00;
      4'h9: f_decode = 7'h04;
      4'hA: f_decode = 7'h08;
      4'hB: f_decode = 7'h60;
      4'hC: f_decode = 7'h31;
      4'hD: f_decode = 7'h42;
      4'hE: f_decode = 7'h30;
      default: f_decode = 7'h38;
    endcase
  endfunction

  assign w_tick = enable && (r_cnt == CNT_MAX);
  assign w_wrap = w_tick && (r_idx == IDX_MAX);

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    w_all_zero = 1'b1;
    w_lz       = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_all_zero = w_all_zero && (r_shad_val[4*i +: 4] == 4'h0);
      w_lz[i]    = blank_lz && (i != 0) && w_all_zero;
    end
  end

  always_comb begin
    w_digit  = 4'h0;
    w_dp_bit = 1'b0;
    w_blank  = 1'b0;
    w_an_nxt = AN_OFF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_digit     = r_shad_val[4*i +: 4];
        w_dp_bit    = r_shad_dp[i];
        w_blank     = w_lz[i];
        w_an_nxt[i] = ~AN_OFF[i];
      end
    end
    w_seg_nxt = 7'h7F;
    w_dp_nxt  = 1'b1;
    if (enable && (r_cnt != '0)) begin
      w_seg_nxt = w_blank ? 7'h7F : f_decode(w_digit);
      w_dp_nxt  = ~w_dp_bit;
    end else begin
      w_an_nxt = AN_OFF;
    end
  end

  // Shadow only changes on the wrap tick so a frame never mixes old and new digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_shad_val   <= '0;
      r_shad_dp    <= '0;
      r_seg        <= 7'h7F;
      r_dp         <= 1'b1;
      r_an         <= AN_OFF;
      r_frame_done <= 1'b0;
    end else begin
      if (w_tick) begin
        r_cnt <= '0;
        r_idx <= w_wrap ? '0 : r_idx + IDX_W'(1);
      end else if (enable) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (load) begin
        r_pend_val <= value;
        r_pend_dp  <= dp_in;
      end
      if (w_wrap) begin
        r_shad_val <= load ? value : r_pend_val;
        r_shad_dp  <= load ? dp_in : r_pend_dp;
      end
      r_seg        <= w_seg_nxt;
      r_dp         <= w_dp_nxt;
      r_an         <= w_an_nxt;
      r_frame_done <= w_wrap;
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: 4-digit active-low anodes with a short slot,
// plus a single-digit active-high-anode instance.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;
  logic [6:0]  seg1;
  logic        dp1;
  logic [0:0]  an1;
  logic        frame_done1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .ANODE_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an),
    .frame_done(frame_done)
  );

  seg_scan_driver #(.NUM_DIGITS(1), .SCAN_DIV(3), .ANODE_ACTIVE_LOW(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value[3:0]),
    .dp_in(dp_in[0:0]), .blank_lz(blank_lz), .seg(seg1), .dp(dp1), .an(an1),
    .frame_done(frame_done1)
  );

  // Returns on the sample where the selected instance shows its frame pulse.
  task automatic wait_frame(input bit single);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if ((single ? frame_done1 : frame_done) === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL wait_frame single=%0b: no frame_done within 40 cycles, required 1", single);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp, frame_done} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset: an=%b seg=%h dp=%b fd=%b, required an=1111 seg=7f dp=1 fd=0",
               an, seg, dp, frame_done);
    end
    checks++;
    if ({an1, seg1, dp1, frame_done1} !== {1'b0, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_single: an=%b seg=%h dp=%b fd=%b, required an=0 seg=7f dp=1 fd=0",
               an1, seg1, dp1, frame_done1);
    end
  endtask

  task automatic test_scan();
    logic [6:0] eSegTab [4] = '{7'h38, 7'h08, 7'h12, 7'h4F};
    logic [3:0] eAn;
    logic [6:0] eSeg;
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
    value  = 16'h12AF;
    dp_in  = 4'h0;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_frame(1'b0);
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      eAn  = 4'b1111;
      eSeg = 7'h7F;
      if (n % 4 != 0) begin
        eAn[n/4] = 1'b0;
        eSeg     = eSegTab[n/4];
      end
      checks++;
      if ({an, seg, dp, frame_done} !== {eAn, eSeg, 1'b1, (n == 15)}) begin
        errors++;
        $display("[TB] FAIL scan n=%0d: an=%b seg=%h dp=%b fd=%b, required an=%b seg=%h dp=1 fd=%b",
                 n, an, seg, dp, frame_done, eAn, eSeg, (n == 15));
      end
    end
  endtask

  task automatic test_blanking();
    logic [6:0] eSegTab [2][4] = '{'{7'h01, 7'h4C, 7'h7F, 7'h7F}, '{7'h01, 7'h7F, 7'h7F, 7'h7F}};
    logic [3:0] eDpTab  [2]    = '{4'b1011, 4'b1111};
    logic [15:0] valTab [2]    = '{16'h0040, 16'h0000};
    logic [3:0] dpInTab [2]    = '{4'b0100, 4'b0000};
    logic [3:0] eAn;
    logic [6:0] eSeg;
    logic       eDp;
    blank_lz = 1'b1;
    for (int t = 0; t < 2; t++) begin
      value = valTab[t];
      dp_in = dpInTab[t];
      load  = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_frame(1'b0);
      for (int n = 0; n < 16; n++) begin
        @(negedge clk);
        eAn  = 4'b1111;
        eSeg = 7'h7F;
        eDp  = 1'b1;
        if (n % 4 != 0) begin
          eAn[n/4] = 1'b0;
          eSeg     = eSegTab[t][n/4];
          eDp      = eDpTab[t][n/4];
        end
        checks++;
        if ({an, seg, dp} !== {eAn, eSeg, eDp}) begin
          errors++;
          $display("[TB] FAIL blank t=%0d n=%0d: an=%b seg=%h dp=%b, required an=%b seg=%h dp=%b",
                   t, n, an, seg, dp, eAn, eSeg, eDp);
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_tear_free();
    logic [6:0] eSegFrame [3] = '{7'h12, 7'h4F, 7'h06};
    logic [3:0] eAn;
    logic [6:0] eSeg;
    value = 16'h2222;
    dp_in = 4'h0;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_frame(1'b0);
    for (int f = 0; f < 3; f++) begin
      for (int n = 0; n < 16; n++) begin
        @(negedge clk);
        eAn  = 4'b1111;
        eSeg = 7'h7F;
        if (n % 4 != 0) begin
          eAn[n/4] = 1'b0;
          eSeg     = eSegFrame[f];
        end
        checks++;
        if ({an, seg, frame_done} !== {eAn, eSeg, (n == 15)}) begin
          errors++;
          $display("[TB] FAIL tear f=%0d n=%0d: an=%b seg=%h fd=%b, required an=%b seg=%h fd=%b",
                   f, n, an, seg, frame_done, eAn, eSeg, (n == 15));
        end
        if (f == 0 && n == 5) begin
          value = 16'h1111;
          load  = 1'b1;
        end
        if (f == 1 && n == 14) begin
          value = 16'h3333;
          load  = 1'b1;
        end
        if ((f == 0 && n == 6) || (f == 1 && n == 15)) load = 1'b0;
      end
    end
  endtask

  task automatic test_enable_hold();
    logic [3:0] eAnTab  [6] = '{4'b1011, 4'b1011, 4'b1111, 4'b0111, 4'b0111, 4'b0111};
    logic [6:0] eSegTab [6] = '{7'h06, 7'h06, 7'h7F, 7'h06, 7'h06, 7'h06};
    repeat (10) @(negedge clk);
    enable = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, frame_done} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) begin
        errors++;
        $display("[TB] FAIL disabled n=%0d: an=%b seg=%h dp=%b fd=%b, required an=1111 seg=7f dp=1 fd=0",
                 n, an, seg, dp, frame_done);
      end
    end
    enable = 1'b1;
    for (int m = 0; m < 6; m++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, frame_done} !== {eAnTab[m], eSegTab[m], (m == 5)}) begin
        errors++;
        $display("[TB] FAIL resume m=%0d: an=%b seg=%h fd=%b, required an=%b seg=%h fd=%b",
                 m, an, seg, frame_done, eAnTab[m], eSegTab[m], (m == 5));
      end
    end
  endtask

  task automatic test_async_reset();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp, frame_done} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL async_reset: an=%b seg=%h dp=%b fd=%b, required an=1111 seg=7f dp=1 fd=0",
               an, seg, dp, frame_done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({an, seg} !== {4'b1111, 7'h7F}) begin
      errors++;
      $display("[TB] FAIL post_reset_guard: an=%b seg=%h, required an=1111 seg=7f", an, seg);
    end
    @(negedge clk);
    checks++;
    if ({an, seg, dp} !== {4'b1110, 7'h01, 1'b1}) begin
      errors++;
      $display("[TB] FAIL post_reset_digit0: an=%b seg=%h dp=%b, required an=1110 seg=01 dp=1",
               an, seg, dp);
    end
  endtask

  task automatic test_single_digit();
    value = 16'h0005;
    dp_in = 4'b0001;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_frame(1'b1);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (n % 3 == 0) begin
        checks++;
        if ({an1, seg1, dp1, frame_done1} !== {1'b0, 7'h7F, 1'b1, 1'b0}) begin
          errors++;
          $display("[TB] FAIL single_guard n=%0d: an=%b seg=%h dp=%b fd=%b, required an=0 seg=7f dp=1 fd=0",
                   n, an1, seg1, dp1, frame_done1);
        end
      end else begin
        checks++;
        if ({an1, seg1, dp1, frame_done1} !== {1'b1, 7'h24, 1'b0, (n % 3 == 2)}) begin
          errors++;
          $display("[TB] FAIL single_digit n=%0d: an=%b seg=%h dp=%b fd=%b, required an=1 seg=24 dp=0 fd=%b",
                   n, an1, seg1, dp1, frame_done1, (n % 3 == 2));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blanking();
    test_tear_free();
    test_enable_hold();
    test_async_reset();
    test_single_digit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
